// File: rtl/toyseq_pkg.sv
// rtl/toyseq_pkg.sv - shared command encodings, FSM states and sizes for the toy CPU sequencer
package toyseq_pkg;

   localparam int DEF_SCAN_LEN = 19;
   localparam int RUN_CNT_W    = 7;

   typedef enum logic [1:0] {
      CMD_WR   = 2'b00,
      CMD_PTR  = 2'b01,
      CMD_RUN  = 2'b10,
      CMD_SCAN = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CRST,
      ST_RUN,
      ST_SCAN,
      ST_RESP
   } state_e;

endpackage

// File: rtl/toyseq_mem.sv
// rtl/toyseq_mem.sv - 16x8 register file, combinational read, synchronous write, no reset
module toyseq_mem (
   input  logic       clk,
   input  logic       we_i,
   input  logic [3:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [3:0] raddr_i,
   output logic [7:0] rdata_o
);

   logic [7:0] mem_q [16];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/toycpu_sequencer.sv
// rtl/toycpu_sequencer.sv - host loader, CPU reset/run/scan sequencer and memory arbiter
// TOYSEQ_CPU_WRITE_EN: when defined, CPU stores update memory during RUN.
module toycpu_sequencer
   import toyseq_pkg::*;
#(
   parameter int SCAN_LEN = DEF_SCAN_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_valid,
   output logic                host_ready,
   input  logic [1:0]          host_cmd,
   input  logic [7:0]          host_data,
   output logic                busy,
   output logic                resp_valid,
   output logic [SCAN_LEN-1:0] resp_data,
   output logic                cpu_rst,
   output logic                cpu_clk_en,
   output logic                cpu_scan_en,
   input  logic                cpu_scan_out,
   input  logic [3:0]          cpu_addr,
   input  logic                cpu_we,
   input  logic [7:0]          cpu_data_out,
   output logic [7:0]          cpu_data_in
);

   localparam int SCNT_W = $clog2(SCAN_LEN);

   state_e                state_q, state_d;
   logic [3:0]            ptr_q, ptr_d;
   logic [RUN_CNT_W-1:0]  cnt_q, cnt_d;
   logic [SCNT_W-1:0]     scnt_q, scnt_d;
   logic [SCAN_LEN-1:0]   sreg_q, sreg_d;

   logic       mem_we;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   toyseq_mem u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (cpu_addr),
      .rdata_o (mem_rdata)
   );

`ifndef TOYSEQ_CPU_WRITE_EN
   logic unused_cpu_wr;
   assign unused_cpu_wr = ^{cpu_we, cpu_data_out};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         scnt_q  <= '0;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         scnt_q  <= scnt_d;
         sreg_q  <= sreg_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      scnt_d      = scnt_q;
      sreg_d      = sreg_q;
      host_ready  = 1'b0;
      busy        = 1'b1;
      resp_valid  = 1'b0;
      resp_data   = '0;
      cpu_rst     = 1'b0;
      cpu_clk_en  = 1'b0;
      cpu_scan_en = 1'b0;
      cpu_data_in = 8'h00;
      mem_we      = 1'b0;
      mem_waddr   = ptr_q;
      mem_wdata   = host_data;

      case (state_q)
         ST_IDLE: begin
            host_ready = 1'b1;
            busy       = 1'b0;
            if (host_valid) begin
               case (cmd_e'(host_cmd))
                  CMD_WR: begin
                     mem_we = 1'b1;
                     ptr_d  = ptr_q + 4'd1;
                  end
                  CMD_PTR: ptr_d = host_data[3:0];
                  CMD_RUN: begin
                     // A count of 0 runs 128 cycles: the 7-bit decrement wraps through 127..1.
                     cnt_d   = host_data[RUN_CNT_W-1:0];
                     state_d = host_data[7] ? ST_CRST : ST_RUN;
                  end
                  CMD_SCAN: begin
                     scnt_d  = '0;
                     state_d = ST_SCAN;
                  end
                  default: ;
               endcase
            end
         end
         ST_CRST: begin
            cpu_rst     = 1'b1;
            cpu_clk_en  = 1'b1;
            cpu_data_in = mem_rdata;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            cpu_clk_en  = 1'b1;
            cpu_data_in = mem_rdata;
            cnt_d       = cnt_q - RUN_CNT_W'(1);
            if (cnt_q == RUN_CNT_W'(1)) state_d = ST_IDLE;
`ifdef TOYSEQ_CPU_WRITE_EN
            if (cpu_we) begin
               mem_we    = 1'b1;
               mem_waddr = cpu_addr;
               mem_wdata = cpu_data_out;
            end
`endif
         end
         ST_SCAN: begin
            cpu_scan_en = 1'b1;
            cpu_clk_en  = 1'b1;
            sreg_d      = {sreg_q[SCAN_LEN-2:0], cpu_scan_out};
            scnt_d      = scnt_q + SCNT_W'(1);
            if (scnt_q == SCNT_W'(SCAN_LEN - 1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_data  = sreg_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_toycpu_sequencer.sv
// tb/tb_toycpu_sequencer.sv - directed self-checking bench for toycpu_sequencer
module tb_toycpu_sequencer;

   localparam int SL = 19;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic [1:0]    host_cmd = 2'b00;
   logic [7:0]    host_data = 8'h00;
   logic          busy;
   logic          resp_valid;
   logic [SL-1:0] resp_data;
   logic          cpu_rst;
   logic          cpu_clk_en;
   logic          cpu_scan_en;
   logic          cpu_scan_out = 1'b0;
   logic [3:0]    cpu_addr = 4'h0;
   logic          cpu_we = 1'b0;
   logic [7:0]    cpu_data_out = 8'h00;
   logic [7:0]    cpu_data_in;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   toycpu_sequencer #(.SCAN_LEN(SL)) dut (
      .clk          (clk),
      .rst          (rst),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_cmd     (host_cmd),
      .host_data    (host_data),
      .busy         (busy),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .cpu_rst      (cpu_rst),
      .cpu_clk_en   (cpu_clk_en),
      .cpu_scan_en  (cpu_scan_en),
      .cpu_scan_out (cpu_scan_out),
      .cpu_addr     (cpu_addr),
      .cpu_we       (cpu_we),
      .cpu_data_out (cpu_data_out),
      .cpu_data_in  (cpu_data_in)
   );

   // Present one command for a single cycle; caller guarantees IDLE.
   task automatic send(input logic [1:0] cmd, input logic [7:0] data);
      host_valid = 1'b1;
      host_cmd   = cmd;
      host_data  = data;
      @(posedge clk);
      #1;
      host_valid = 1'b0;
   endtask

   // Observe a run until host_ready returns; addrs supplies cpu_addr per run cycle, rd collects reads.
   task automatic watch(input int max_cyc, input logic [15:0] addrs,
                        output int n_rst, output int n_en, output int done_at,
                        output int n_hs_bad, output logic [31:0] rd);
      int k;
      n_rst = 0; n_en = 0; done_at = -1; n_hs_bad = 0; rd = '0; k = 0;
      cpu_addr = addrs[3:0];
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (busy === host_ready) n_hs_bad++;
         if (host_ready === 1'b1) begin
            done_at = c;
            break;
         end
         if (cpu_rst === 1'b1) n_rst++;
         else if (cpu_clk_en === 1'b1) begin
            if (k < 4) rd[8*k +: 8] = cpu_data_in;
            n_en++;
            k++;
            if (k < 4) cpu_addr = addrs[4*k +: 4];
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready got %b exp 1", host_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (resp_valid !== 1'b0 || resp_data !== '0) begin errors++; $display("FAIL reset_resp got %b/%h exp 0/0", resp_valid, resp_data); end
      checks++; if ({cpu_rst, cpu_clk_en, cpu_scan_en} !== 3'b000) begin errors++; $display("FAIL reset_cpu_ctl got %b exp 000", {cpu_rst, cpu_clk_en, cpu_scan_en}); end
      checks++; if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in got %h exp 00", cpu_data_in); end
   endtask

   task automatic test_run_reset;
      int nr, ne, da, hb;
      logic [31:0] rd;
      send(2'b00, 8'h15);
      send(2'b00, 8'h45);
      send(2'b00, 8'h30);
      send(2'b01, 8'h00);
      send(2'b10, 8'h83);
      watch(10, 16'h0210, nr, ne, da, hb, rd);
      checks++; if (nr != 1) begin errors++; $display("FAIL run_rst_pulses got %0d exp 1", nr); end
      checks++; if (ne != 3) begin errors++; $display("FAIL run_rst_clk_en got %0d exp 3", ne); end
      checks++; if (da != 5) begin errors++; $display("FAIL run_rst_idle_at got %0d exp 5", da); end
      checks++; if (hb != 0) begin errors++; $display("FAIL run_rst_busy_ready got %0d bad cycles exp 0", hb); end
      checks++; if (rd[23:0] !== 24'h304515) begin errors++; $display("FAIL run_rst_mem got %h exp 304515", rd[23:0]); end
   endtask

   task automatic test_ptr_wrap;
      int nr, ne, da, hb;
      logic [31:0] rd;
      send(2'b01, 8'hAF);
      send(2'b00, 8'hAA);
      send(2'b00, 8'hBB);
      send(2'b10, 8'h02);
      watch(10, 16'h000F, nr, ne, da, hb, rd);
      checks++; if (rd[15:0] !== 16'hBBAA) begin errors++; $display("FAIL ptr_wrap_mem got %h exp BBAA", rd[15:0]); end
      checks++; if (ne != 2 || nr != 0 || da != 3) begin errors++; $display("FAIL run2_timing got en=%0d rst=%0d idle=%0d exp 2/0/3", ne, nr, da); end
   endtask

   task automatic test_run128;
      int nr, ne, da, hb;
      logic [31:0] rd;
      send(2'b10, 8'h00);
      watch(140, 16'h0000, nr, ne, da, hb, rd);
      checks++; if (ne != 128) begin errors++; $display("FAIL run128_clk_en got %0d exp 128", ne); end
      checks++; if (nr != 0 || da != 129) begin errors++; $display("FAIL run128_end got rst=%0d idle=%0d exp 0/129", nr, da); end
      checks++; if (hb != 0) begin errors++; $display("FAIL run128_busy_ready got %0d exp 0", hb); end
   endtask

   task automatic test_scan;
      logic [SL-1:0] pat, rv_data;
      int n_scan, n_rv, rv_at, first_ready;
      pat = 19'h5A5A3;
      n_scan = 0; n_rv = 0; rv_at = -1; first_ready = -1; rv_data = '0;
      send(2'b11, 8'h00);
      cpu_scan_out = pat[SL-1];
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (cpu_scan_en === 1'b1) n_scan++;
         if (resp_valid === 1'b1) begin n_rv++; rv_at = c; rv_data = resp_data; end
         if (host_ready === 1'b1 && first_ready < 0) first_ready = c;
         @(posedge clk);
         #1;
         if (c < SL) cpu_scan_out = pat[SL-1-c];
      end
      checks++; if (n_scan != 19) begin errors++; $display("FAIL scan_en_cycles got %0d exp 19", n_scan); end
      checks++; if (n_rv != 1 || rv_at != 20) begin errors++; $display("FAIL scan_resp_pulse got n=%0d at=%0d exp 1/20", n_rv, rv_at); end
      checks++; if (rv_data !== pat) begin errors++; $display("FAIL scan_resp_data got %h exp %h", rv_data, pat); end
      checks++; if (first_ready != 21) begin errors++; $display("FAIL scan_ready_at got %0d exp 21", first_ready); end
   endtask

   task automatic test_cpu_write;
      int nr, ne, da, hb;
      logic [31:0] rd;
      logic [7:0] exp9;
`ifdef TOYSEQ_CPU_WRITE_EN
      exp9 = 8'h07;
`else
      exp9 = 8'h5C;
`endif
      send(2'b01, 8'h09);
      send(2'b00, 8'h5C);
      cpu_addr = 4'h9; cpu_we = 1'b1; cpu_data_out = 8'h07;
      @(negedge clk);
      checks++; if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL idle_data_in got %h exp 00", cpu_data_in); end
      send(2'b10, 8'h01);
      watch(5, 16'h9999, nr, ne, da, hb, rd);
      checks++; if (rd[7:0] !== 8'h5C) begin errors++; $display("FAIL cpu_wr_pre_read got %h exp 5C", rd[7:0]); end
      cpu_we = 1'b0;
      send(2'b10, 8'h01);
      watch(5, 16'h9999, nr, ne, da, hb, rd);
      checks++; if (rd[7:0] !== exp9) begin errors++; $display("FAIL cpu_wr_mem9 got %h exp %h", rd[7:0], exp9); end
   endtask

   task automatic test_rst_scan;
      int nr, ne, da, hb, n_rv;
      logic [31:0] rd;
      send(2'b11, 8'h00);
      cpu_scan_out = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (host_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_scan_idle got ready=%b busy=%b exp 1/0", host_ready, busy); end
      checks++; if ({cpu_rst, cpu_clk_en, cpu_scan_en} !== 3'b000) begin errors++; $display("FAIL rst_scan_cpu_ctl got %b exp 000", {cpu_rst, cpu_clk_en, cpu_scan_en}); end
      rst = 1'b0;
      cpu_scan_out = 1'b0;
      n_rv = 0;
      repeat (25) begin
         @(negedge clk);
         if (resp_valid === 1'b1) n_rv++;
      end
      checks++; if (n_rv != 0) begin errors++; $display("FAIL rst_scan_no_resp got %0d pulses exp 0", n_rv); end
      send(2'b00, 8'hE1);
      send(2'b10, 8'h01);
      watch(5, 16'h0000, nr, ne, da, hb, rd);
      checks++; if (rd[7:0] !== 8'hE1) begin errors++; $display("FAIL rst_scan_ptr0 got %h exp E1", rd[7:0]); end
   endtask

   initial begin
      test_reset();
      test_run_reset();
      test_ptr_wrap();
      test_run128();
      test_scan();
      test_cpu_write();
      test_rst_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
